// File: rtl/frac_mult_pkg.sv
// Shared types and saturation constants for the signed fraction multiplier.
// Used by fraction_multiplier_n (optional rounding output under FRAC_MULT_ROUND_EN).
package frac_mult_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ITER = 2'd1,
      CORR = 2'd2,
      DONE = 2'd3
   } state_t;

   // Most positive two's-complement pattern of the given width (011...1).
   function automatic logic [31:0] sat_max_pos(input int unsigned width);
      sat_max_pos = (32'd1 << (width - 32'd1)) - 32'd1;
   endfunction

   // Most negative two's-complement pattern of the given width (100...0).
   function automatic logic [31:0] sat_min_neg(input int unsigned width);
      sat_min_neg = 32'd1 << (width - 32'd1);
   endfunction

endpackage

// File: rtl/frac_mult_addsub.sv
// Guard-bit accumulator update: A +/- sext(M), N+1 bits wide.
module frac_mult_addsub #(
   parameter int N = 4
) (
   input  logic [N:0]   i_a,
   input  logic [N-1:0] i_m,
   input  logic         i_sub,
   output logic [N:0]   o_sum
);

   logic [N:0] w_m_ext;

   assign w_m_ext = {i_m[N-1], i_m};
   assign o_sum   = i_sub ? (i_a - w_m_ext) : (i_a + w_m_ext);

endmodule

// File: rtl/fraction_multiplier_n.sv
// N-bit signed Q1.(N-1) shift-and-add multiplier with -1 x -1 saturation.
// Define FRAC_MULT_ROUND_EN to add the rounded N-bit output Product_r.
module fraction_multiplier_n
   import frac_mult_pkg::*;
#(
   parameter int N = 4
) (
   input  logic           CLK,
   input  logic           RST_n,
   input  logic           St,
   input  logic [N-1:0]   Mplier,
   input  logic [N-1:0]   Mcand,
   output logic [2*N-2:0] Product,
   output logic           Done,
   output logic           Busy,
   output logic           Ovf,
`ifdef FRAC_MULT_ROUND_EN
   output logic [N-1:0]   Product_r,
`endif
   output logic [1:0]     Dbg_state
);

   localparam int KW = $clog2(N);
   localparam logic [KW-1:0] LP_K_LAST = KW'(N - 2);
   localparam logic [31:0] LP_NMIN = sat_min_neg(N);
   localparam logic [31:0] LP_PMAX = sat_max_pos(2 * N - 1);

   state_t          r_state;
   logic [N:0]      r_a;
   logic [N-1:0]    r_b;
   logic [N-1:0]    r_m;
   logic [KW-1:0]   r_k;
   logic            r_both_min;

   logic [N:0]      w_sum;
   logic [N:0]      w_a_upd;
   logic [2*N-2:0]  w_prod_next;

   frac_mult_addsub #(.N(N)) u_addsub (
      .i_a   (r_a),
      .i_m   (r_m),
      .i_sub (r_state == CORR),
      .o_sum (w_sum)
   );

   assign w_a_upd     = r_b[0] ? w_sum : r_a;
   assign w_prod_next = r_both_min ? LP_PMAX[2*N-2:0] : {r_a[N-2:0], r_b};
   assign Dbg_state   = r_state;

`ifdef FRAC_MULT_ROUND_EN
   localparam int LP_HALF = 1 << (N - 2);
   localparam logic [31:0] LP_RMAX = sat_max_pos(N);

   logic signed [2*N-1:0] w_rsum;
   logic [N:0]            w_rq;
   logic [N-1:0]          w_rnd;

   // Taking bits [2N-1:N-1] of the widened sum is the arithmetic shift by N-1.
   assign w_rsum = $signed({w_prod_next[2*N-2], w_prod_next}) + $signed(LP_HALF[2*N-1:0]);
   assign w_rq   = w_rsum[2*N-1:N-1];
   assign w_rnd  = (w_rq[N] == w_rq[N-1]) ? w_rq[N-1:0] :
                   (w_rq[N] ? LP_NMIN[N-1:0] : LP_RMAX[N-1:0]);
`endif

   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         r_state    <= IDLE;
         r_a        <= '0;
         r_b        <= '0;
         r_m        <= '0;
         r_k        <= '0;
         r_both_min <= 1'b0;
         Product    <= '0;
         Done       <= 1'b0;
         Busy       <= 1'b0;
         Ovf        <= 1'b0;
`ifdef FRAC_MULT_ROUND_EN
         Product_r  <= '0;
`endif
      end else begin
         Done <= 1'b0;
         Busy <= (r_state != IDLE);
         case (r_state)
            IDLE: begin
               if (St) begin
                  r_a        <= '0;
                  r_b        <= Mplier;
                  r_m        <= Mcand;
                  r_k        <= '0;
                  r_both_min <= (Mplier == LP_NMIN[N-1:0]) && (Mcand == LP_NMIN[N-1:0]);
                  r_state    <= ITER;
               end
            end
            ITER: begin
               r_a <= {w_a_upd[N], w_a_upd[N:1]};
               r_b <= {w_a_upd[0], r_b[N-1:1]};
               r_k <= r_k + 1'b1;
               if (r_k == LP_K_LAST) r_state <= CORR;
            end
            CORR: begin
               // r_b[0] now holds the multiplier sign bit: subtract instead of add.
               r_a     <= {w_a_upd[N], w_a_upd[N:1]};
               r_b     <= {w_a_upd[0], r_b[N-1:1]};
               r_state <= DONE;
            end
            DONE: begin
               Product   <= w_prod_next;
               Ovf       <= r_both_min;
               Done      <= 1'b1;
`ifdef FRAC_MULT_ROUND_EN
               Product_r <= w_rnd;
`endif
               r_state   <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fraction_multiplier_n.sv
// Randomized bench for fraction_multiplier_n at N=4 and N=8 against an integer-arithmetic model.
module tb_fraction_multiplier_n;

   logic        clk = 1'b0;
   logic        rst4_n, rst8_n;
   logic        st4, st8;
   logic [3:0]  mpl4, mcd4;
   logic [7:0]  mpl8, mcd8;
   logic [6:0]  prod4;
   logic [14:0] prod8;
   logic        done4, busy4, ovf4, done8, busy8, ovf8;
   logic [1:0]  dbg4, dbg8;
`ifdef FRAC_MULT_ROUND_EN
   logic [3:0]  prodr4;
   logic [7:0]  prodr8;
`endif

   int checks = 0;
   int failures = 0;
   logic [31:0] exp_q[$];

   always #5 clk = ~clk;

   fraction_multiplier_n #(.N(4)) dut4 (
      .CLK(clk), .RST_n(rst4_n), .St(st4), .Mplier(mpl4), .Mcand(mcd4),
      .Product(prod4), .Done(done4), .Busy(busy4), .Ovf(ovf4),
`ifdef FRAC_MULT_ROUND_EN
      .Product_r(prodr4),
`endif
      .Dbg_state(dbg4)
   );

   fraction_multiplier_n #(.N(8)) dut8 (
      .CLK(clk), .RST_n(rst8_n), .St(st8), .Mplier(mpl8), .Mcand(mcd8),
      .Product(prod8), .Done(done8), .Busy(busy8), .Ovf(ovf8),
`ifdef FRAC_MULT_ROUND_EN
      .Product_r(prodr8),
`endif
      .Dbg_state(dbg8)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Exact signed product of two Q1.(n-1) fractions, with -1 x -1 saturating.
   function automatic void model(input int n, input int a_raw, input int b_raw,
                                 output int p_bits, output int ovf, output int r_bits);
      int sa, sb, p, r, lo, hi;
      sa = (a_raw >= (1 << (n - 1))) ? a_raw - (1 << n) : a_raw;
      sb = (b_raw >= (1 << (n - 1))) ? b_raw - (1 << n) : b_raw;
      p = sa * sb;
      ovf = 0;
      if (sa == -(1 << (n - 1)) && sb == -(1 << (n - 1))) begin
         p = (1 << (2 * n - 2)) - 1;
         ovf = 1;
      end
      r = (p + (1 << (n - 2))) >>> (n - 1);
      lo = -(1 << (n - 1));
      hi = (1 << (n - 1)) - 1;
      if (r > hi) r = hi;
      if (r < lo) r = lo;
      p_bits = p & ((1 << (2 * n - 1)) - 1);
      r_bits = r & ((1 << n) - 1);
   endfunction

   task automatic op4(input logic [3:0] a, input logic [3:0] b, input bit poke);
      int p, o, r, c;
      bit seen;
      logic [31:0] e;
      model(4, int'(a), int'(b), p, o, r);
      exp_q.push_back(32'(p));
      @(negedge clk); st4 = 1'b1; mpl4 = a; mcd4 = b;
      @(negedge clk); st4 = 1'b0; mpl4 = 4'($urandom); mcd4 = 4'($urandom);
      c = 0; seen = 0;
      while (!seen && c < 20) begin
         if (done4) begin
            seen = 1;
            chk("lat4", 32'(c), 32'd5);
            chk("busy_done4", 32'(busy4), 32'd1);
            if (exp_q.size() == 0) chk("q_empty4", 32'd1, 32'd0);
            else begin
               e = exp_q.pop_front();
               chk("prod4", 32'(prod4), e);
            end
            chk("ovf4", 32'(ovf4), 32'(o));
`ifdef FRAC_MULT_ROUND_EN
            chk("prodr4", 32'(prodr4), 32'(r));
`endif
         end else begin
            chk("busy4", 32'(busy4), (c >= 1) ? 32'd1 : 32'd0);
         end
         if (poke && c == 2) begin st4 = 1'b1; mpl4 = ~a; mcd4 = a ^ b ^ 4'h5; end
         if (poke && c == 3) st4 = 1'b0;
         @(negedge clk); c++;
      end
      if (!seen) chk("timeout4", 32'd0, 32'd1);
      chk("done_low4", 32'(done4), 32'd0);
      chk("busy_low4", 32'(busy4), 32'd0);
   endtask

   task automatic op8(input logic [7:0] a, input logic [7:0] b, input int abort_c);
      int p, o, r, c;
      bit seen;
      logic [31:0] e;
      model(8, int'(a), int'(b), p, o, r);
      if (abort_c < 0) exp_q.push_back(32'(p));
      @(negedge clk); st8 = 1'b1; mpl8 = a; mcd8 = b;
      @(negedge clk); st8 = 1'b0; mpl8 = 8'($urandom); mcd8 = 8'($urandom);
      c = 0; seen = 0;
      while (!seen && c < 20) begin
         if (done8) begin
            seen = 1;
            chk("lat8", 32'(c), 32'd9);
            if (exp_q.size() == 0) chk("q_empty8", 32'd1, 32'd0);
            else begin
               e = exp_q.pop_front();
               chk("prod8", 32'(prod8), e);
            end
            chk("ovf8", 32'(ovf8), 32'(o));
`ifdef FRAC_MULT_ROUND_EN
            chk("prodr8", 32'(prodr8), 32'(r));
`endif
         end else if (c == abort_c) begin
            rst8_n = 1'b0;
            #1;
            chk("rst_prod8", 32'(prod8), 32'd0);
            chk("rst_ovf8", 32'(ovf8), 32'd0);
            chk("rst_busy8", 32'(busy8), 32'd0);
            chk("rst_state8", 32'(dbg8), 32'd0);
`ifdef FRAC_MULT_ROUND_EN
            chk("rst_prodr8", 32'(prodr8), 32'd0);
`endif
            @(negedge clk); rst8_n = 1'b1; c++;
         end
         @(negedge clk); c++;
      end
      if (abort_c >= 0) chk("abort_nodone8", 32'(seen), 32'd0);
      else chk("timeout8", 32'(seen), 32'd1);
   endtask

   initial begin
      rst4_n = 1'b0; rst8_n = 1'b0;
      st4 = 1'b0; st8 = 1'b0;
      mpl4 = '0; mcd4 = '0; mpl8 = '0; mcd8 = '0;
      #1;
      chk("rst_prod4", 32'(prod4), 32'd0);
      chk("rst_done4", 32'(done4), 32'd0);
      chk("rst_busy4", 32'(busy4), 32'd0);
      chk("rst_ovf4", 32'(ovf4), 32'd0);
      chk("rst_state4", 32'(dbg4), 32'd0);
      repeat (2) @(negedge clk);
      rst4_n = 1'b1; rst8_n = 1'b1;

      op4(4'h4, 4'h4, 1'b0);
      op4(4'hC, 4'h4, 1'b0);
      op4(4'h7, 4'h9, 1'b0);
      op4(4'h8, 4'h8, 1'b0);
      op4(4'h3, 4'h5, 1'b1);
      op4(4'h8, 4'h7, 1'b0);
      op4(4'h0, 4'h8, 1'b0);
      for (int i = 0; i < 30; i++) op4(4'($urandom), 4'($urandom), 1'($urandom_range(0, 1)));

      op8(8'hA7, 8'h5B, -1);
      op8(8'h3C, 8'hD1, 3);
      op8(8'h40, 8'h40, -1);
      op8(8'h80, 8'h80, -1);
      op8(8'h80, 8'h7F, -1);
      for (int i = 0; i < 15; i++) op8(8'($urandom), 8'($urandom), -1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
